// File: rtl/block_transfer_seq.sv
// ---------------------------------------------------------------------------
// block_transfer_seq
//
// Multi-cycle LDM/STM sequencer for the ARMv4T core. A decoded block-transfer
// instruction is accepted in IDLE. The register list is walked lowest-first,
// with one word access per register on the mem_ok-handshaked bus. The block
// drives the register-file read/write ports and the base writeback.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   start_i            launch request, sampled only in IDLE
//   reg_list_i         register mask, bit i = register i
//   base_i, base_idx_i base register value and number (Rn)
//   p_bit_i, u_bit_i   pre-index / up addressing mode bits
//   w_bit_i, l_bit_i   writeback / load (1) versus store (0)
//   rd_idx_o, rd_data_i  register-file read port (combinational read)
//   wr_en_o, wr_idx_o, wr_data_o  register-file write port
//   mem_addr_o, mem_wdata_o, mem_rdata_i, mem_read_o, mem_write_o, mem_ok_i
//                      word-access bus; mem_ok_i completes the access
//   busy_o             high while in XFER or DONE
//   done_o             one-cycle completion pulse
//   wb_en_o, wb_data_o base writeback strobe and value, with done_o
// ---------------------------------------------------------------------------
module block_transfer_seq #(
    parameter int NREGS  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [NREGS-1:0]  reg_list_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [IDX_W-1:0]  base_idx_i,
    input  logic              p_bit_i,
    input  logic              u_bit_i,
    input  logic              w_bit_i,
    input  logic              l_bit_i,
    output logic [IDX_W-1:0]  rd_idx_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic              mem_ok_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] wb_data_o
);

    localparam int STEP  = DATA_W / 8;
    localparam int CNT_W = $clog2(NREGS + 1);
    localparam logic [ADDR_W-1:0] STEP_A   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ADDR_MSK = ~ADDR_W'(STEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [NREGS-1:0]   mask_q;
    logic [NREGS-1:0]   mask_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  startAddr_d;
    logic [ADDR_W-1:0]  wbVal_q;
    logic [ADDR_W-1:0]  wbVal_d;
    logic               wbPend_q;
    logic               wbPend_d;
    logic               memRead_q;
    logic               memWrite_q;
    logic               busy_q;
    logic               done_q;
    logic               wbEn_q;
    logic [ADDR_W-1:0]  wbData_q;
    logic [IDX_W-1:0]   curIdx;
    logic [CNT_W-1:0]   regCount;
    logic [ADDR_W-1:0]  span;

    function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Launch-time arithmetic: the lowest address of the block and the
    // final base value. Transfers always ascend, so the decrementing modes
    // start N words below the base and walk upward.
    always_comb begin
        regCount = popcount(reg_list_i);
        span     = ADDR_W'(regCount) * STEP_A;
        case ({p_bit_i, u_bit_i})
            2'b01:   startAddr_d = base_i;
            2'b11:   startAddr_d = base_i + STEP_A;
            2'b00:   startAddr_d = base_i - span + STEP_A;
            default: startAddr_d = base_i - span;
        endcase
        wbVal_d  = u_bit_i ? (base_i + span) : (base_i - span);
        // A load that overwrites the base register wins over writeback.
        wbPend_d = w_bit_i & ~(l_bit_i & reg_list_i[base_idx_i]);
    end

    // Current register is the lowest set bit of the remaining mask;
    // retiring a beat simply clears that bit.
    always_comb begin
        curIdx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                curIdx = IDX_W'(i);
            end
        end
        mask_d = mask_q & (mask_q - NREGS'(1));
    end

    // Sequencer FSM. All bus requests and status strobes are registered
    // here; only the data paths that must follow the same-cycle handshake
    // are combinational below.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            addr_q     <= '0;
            wbVal_q    <= '0;
            wbPend_q   <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wbEn_q     <= 1'b0;
            wbData_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mask_q   <= reg_list_i;
                        addr_q   <= startAddr_d;
                        wbVal_q  <= wbVal_d;
                        wbPend_q <= wbPend_d;
                        busy_q   <= 1'b1;
                        if (reg_list_i != '0) begin
                            state_q    <= XFER;
                            memRead_q  <= l_bit_i;
                            memWrite_q <= ~l_bit_i;
                        end else begin
                            // Empty list: no bus activity, straight to completion.
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            wbEn_q   <= wbPend_d;
                            wbData_q <= wbVal_d;
                        end
                    end
                end
                XFER: begin
                    if (mem_ok_i) begin
                        mask_q <= mask_d;
                        addr_q <= addr_q + STEP_A;
                        if (mask_d == '0) begin
                            state_q    <= DONE;
                            memRead_q  <= 1'b0;
                            memWrite_q <= 1'b0;
                            done_q     <= 1'b1;
                            wbEn_q     <= wbPend_q;
                            wbData_q   <= wbVal_q;
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    wbEn_q   <= 1'b0;
                    wbData_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register-file write and store data track the handshake in the same
    // cycle, so they are decoded from the registered requests.
    always_comb begin
        rd_idx_o    = curIdx;
        wr_idx_o    = curIdx;
        wr_en_o     = memRead_q & mem_ok_i;
        wr_data_o   = (memRead_q & mem_ok_i) ? mem_rdata_i : '0;
        mem_wdata_o = memWrite_q ? rd_data_i : '0;
        mem_addr_o  = addr_q & ADDR_MSK;
        mem_read_o  = memRead_q;
        mem_write_o = memWrite_q;
        busy_o      = busy_q;
        done_o      = done_q;
        wb_en_o     = wbEn_q;
        wb_data_o   = wbData_q;
    end

endmodule

// File: tb/tb_block_transfer_seq.sv
// ---------------------------------------------------------------------------
// Testbench for block_transfer_seq. A register-file array answers the
// combinational read port, the bench plays the memory side (mem_ok and
// load data), and each transfer is recorded cycle by cycle so that the
// scenario tasks can compare it against a list-walking reference model.
// ---------------------------------------------------------------------------
module tb_block_transfer_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [15:0] regList;
    logic [31:0] base;
    logic [3:0]  baseIdx;
    logic        pBit, uBit, wBit, lBit;
    logic [3:0]  rdIdx;
    logic [31:0] rdData;
    logic        wrEn;
    logic [3:0]  wrIdx;
    logic [31:0] wrData;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memRead, memWrite, memOk;
    logic        busy, done, wbEn;
    logic [31:0] wbData;

    logic [31:0] regFile [16];

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  rdIdx;
        logic        ok;
        logic        wrEn;
        logic [3:0]  wrIdx;
        logic [31:0] wrData;
        logic [31:0] rdata;
    } rec_t;

    rec_t        recs[$];
    int          doneCycle;
    logic        wbEnSeen;
    logic [31:0] wbDataSeen;
    int          extraWr;
    int          busyBad;
    int          accessInDone;
    logic [4:0]  idleFlags;

    logic [31:0] expAddr[$];
    int          expIdx[$];
    logic        expWbEn;
    logic [31:0] expWbData;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rdData = regFile[rdIdx];

    block_transfer_seq dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start),
        .reg_list_i  (regList),
        .base_i      (base),
        .base_idx_i  (baseIdx),
        .p_bit_i     (pBit),
        .u_bit_i     (uBit),
        .w_bit_i     (wBit),
        .l_bit_i     (lBit),
        .rd_idx_o    (rdIdx),
        .rd_data_i   (rdData),
        .wr_en_o     (wrEn),
        .wr_idx_o    (wrIdx),
        .wr_data_o   (wrData),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_rdata_i (memRdata),
        .mem_read_o  (memRead),
        .mem_write_o (memWrite),
        .mem_ok_i    (memOk),
        .busy_o      (busy),
        .done_o      (done),
        .wb_en_o     (wbEn),
        .wb_data_o   (wbData)
    );

    // Reference model: list the registers in ascending order, place the
    // block from the addressing mode, and derive the final base value.
    task automatic build_model(input logic [15:0] list, input logic [31:0] b,
                               input logic [3:0] bidx,
                               input logic p, input logic u, input logic w, input logic l);
        logic [31:0] a0;
        logic [31:0] sp;
        expAddr.delete();
        expIdx.delete();
        for (int i = 0; i < 16; i++) begin
            if (list[i]) expIdx.push_back(i);
        end
        sp = 32'(expIdx.size()) * 32'd4;
        if (u && !p)      a0 = b;
        else if (u && p)  a0 = b + 32'd4;
        else if (!u && !p) a0 = b - sp + 32'd4;
        else              a0 = b - sp;
        for (int k = 0; k < expIdx.size(); k++) begin
            expAddr.push_back((a0 + 32'(k) * 32'd4) & 32'hFFFF_FFFC);
        end
        expWbData = u ? (b + sp) : (b - sp);
        expWbEn   = w && !(l && list[bidx]);
    endtask

    task automatic randomize_regfile();
        for (int i = 0; i < 16; i++) regFile[i] = $urandom;
    endtask

    // Runs one instruction and records every bus-request cycle. The bench
    // scrambles the instruction inputs after launch, since they must have
    // been captured. In random mode start is also toggled while busy.
    task automatic drive_transfer(input logic [15:0] list, input logic [31:0] b,
                                  input logic [3:0] bidx,
                                  input logic p, input logic u, input logic w, input logic l,
                                  input int waitBeat, input int waitLen, input bit randMode);
        int   beats;
        int   waitCnt;
        logic ok;
        rec_t r;
        recs.delete();
        doneCycle = -1; extraWr = 0; busyBad = 0; accessInDone = 0;
        beats = 0; waitCnt = 0;
        @(negedge clk);
        regList = list; base = b; baseIdx = bidx;
        pBit = p; uBit = u; wBit = w; lBit = l;
        start = 1'b1; memOk = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            regList = 16'($urandom); base = $urandom; baseIdx = 4'($urandom);
            {pBit, uBit, wBit, lBit} = 4'($urandom);
            if (randMode) start = 1'($urandom_range(0, 1));
            if (memRead || memWrite) begin
                if (randMode) ok = ($urandom_range(0, 2) != 0);
                else if (beats == waitBeat && waitCnt < waitLen) begin
                    ok = 1'b0;
                    waitCnt++;
                end else ok = 1'b1;
            end else begin
                ok = 1'($urandom_range(0, 1));
            end
            memOk = ok;
            memRdata = $urandom;
            @(negedge clk);
            if (memRead || memWrite) begin
                r.addr = memAddr; r.rd = memRead; r.wr = memWrite;
                r.wdata = memWdata; r.rdIdx = rdIdx; r.ok = ok;
                r.wrEn = wrEn; r.wrIdx = wrIdx; r.wrData = wrData; r.rdata = memRdata;
                recs.push_back(r);
                if (ok) beats++;
            end
            if (wrEn && !(memRead && ok)) extraWr++;
            if (busy !== 1'b1) busyBad++;
            if (done === 1'b1) begin
                doneCycle = c;
                wbEnSeen = wbEn;
                wbDataSeen = wbData;
                if (memRead || memWrite) accessInDone++;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        memOk = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        idleFlags = {busy, done, wbEn, memRead, memWrite};
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; regList = 16'hFFFF; memOk = 1'b1;
        base = 32'h100; baseIdx = 4'd0; {pBit, uBit, wBit, lBit} = 4'b0111;
        memRdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({memRead, memWrite, wrEn, busy, done, wbEn} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b expected 000000",
                     {memRead, memWrite, wrEn, busy, done, wbEn});
        end
        start = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({memRead, memWrite, busy, done} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_release_idle: got %b expected 0000",
                     {memRead, memWrite, busy, done});
        end
    endtask

    task automatic test_stmia();
        randomize_regfile();
        drive_transfer(16'h000F, 32'h100, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
        total++;
        if (recs.size() !== 4) begin
            bad++;
            $display("[TB] FAIL stmia_beats: got %0d expected 4", recs.size());
        end
        for (int j = 0; j < recs.size() && j < 4; j++) begin
            total++;
            if (recs[j].addr !== 32'h100 + 32'(j) * 4 || recs[j].wr !== 1'b1 ||
                recs[j].wdata !== regFile[j]) begin
                bad++;
                $display("[TB] FAIL stmia_beat%0d: got addr=%0h wr=%b data=%0h expected addr=%0h wr=1 data=%0h",
                         j, recs[j].addr, recs[j].wr, recs[j].wdata, 32'h100 + 32'(j) * 4, regFile[j]);
            end
        end
        total++;
        if (doneCycle + 1 !== 6) begin
            bad++;
            $display("[TB] FAIL stmia_latency: got %0d expected 6", doneCycle + 1);
        end
        total++;
        if (wbEnSeen !== 1'b0 || extraWr !== 0) begin
            bad++;
            $display("[TB] FAIL stmia_wb_wr: got wb_en=%b extra_wr=%0d expected 0 0", wbEnSeen, extraWr);
        end
    endtask

    task automatic test_ldmdb_wb();
        logic [31:0] ea[3];
        int          ei[3];
        ea[0] = 32'h1F4; ea[1] = 32'h1F8; ea[2] = 32'h1FC;
        ei[0] = 0; ei[1] = 4; ei[2] = 15;
        drive_transfer(16'h8011, 32'h200, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0);
        total++;
        if (recs.size() !== 3) begin
            bad++;
            $display("[TB] FAIL ldmdb_beats: got %0d expected 3", recs.size());
        end
        for (int j = 0; j < recs.size() && j < 3; j++) begin
            total++;
            if (recs[j].addr !== ea[j] || recs[j].rd !== 1'b1 || recs[j].wrEn !== 1'b1 ||
                recs[j].wrIdx !== 4'(ei[j]) || recs[j].wrData !== recs[j].rdata) begin
                bad++;
                $display("[TB] FAIL ldmdb_beat%0d: got addr=%0h wr_en=%b idx=%0d data=%0h expected addr=%0h wr_en=1 idx=%0d data=%0h",
                         j, recs[j].addr, recs[j].wrEn, recs[j].wrIdx, recs[j].wrData,
                         ea[j], ei[j], recs[j].rdata);
            end
        end
        total++;
        if (wbEnSeen !== 1'b1 || wbDataSeen !== 32'h1F4) begin
            bad++;
            $display("[TB] FAIL ldmdb_wb: got en=%b data=%0h expected en=1 data=1f4", wbEnSeen, wbDataSeen);
        end
    endtask

    task automatic test_ldm_base_in_list();
        drive_transfer(16'h0006, 32'h300, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
        total++;
        if (recs.size() !== 2 || recs[0].wrIdx !== 4'd1 || recs[1].wrIdx !== 4'd2 ||
            recs[0].addr !== 32'h300 || recs[1].addr !== 32'h304) begin
            bad++;
            $display("[TB] FAIL ldm_base_list_beats: got n=%0d expected r1@300 r2@304", recs.size());
        end
        total++;
        if (wbEnSeen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ldm_base_list_wb: got wb_en=%b expected 0", wbEnSeen);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] ea[6];
        ea[0] = 32'h404; ea[1] = 32'h408; ea[2] = 32'h408;
        ea[3] = 32'h408; ea[4] = 32'h408; ea[5] = 32'h40C;
        randomize_regfile();
        drive_transfer(16'h0E00, 32'h400, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 3, 1'b0);
        total++;
        if (recs.size() !== 6) begin
            bad++;
            $display("[TB] FAIL wait_cycles: got %0d expected 6", recs.size());
        end
        for (int j = 0; j < recs.size() && j < 6; j++) begin
            logic [31:0] ed;
            ed = (j == 0) ? regFile[9] : (j == 5) ? regFile[11] : regFile[10];
            total++;
            if (recs[j].addr !== ea[j] || recs[j].wdata !== ed || recs[j].wr !== 1'b1) begin
                bad++;
                $display("[TB] FAIL wait_hold%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                         j, recs[j].addr, recs[j].wdata, ea[j], ed);
            end
        end
        total++;
        if (doneCycle + 1 !== 8) begin
            bad++;
            $display("[TB] FAIL wait_latency: got %0d expected 8", doneCycle + 1);
        end
    endtask

    task automatic test_empty_list();
        drive_transfer(16'h0000, 32'h1234_5678, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0);
        total++;
        if (recs.size() !== 0 || doneCycle !== 1) begin
            bad++;
            $display("[TB] FAIL empty_timing: got accesses=%0d done_cycle=%0d expected 0 1",
                     recs.size(), doneCycle);
        end
        total++;
        if (wbEnSeen !== 1'b1 || wbDataSeen !== 32'h1234_5678 || extraWr !== 0) begin
            bad++;
            $display("[TB] FAIL empty_wb: got en=%b data=%0h wr=%0d expected 1 12345678 0",
                     wbEnSeen, wbDataSeen, extraWr);
        end
    endtask

    task automatic test_stm_base_in_list();
        randomize_regfile();
        regFile[4] = 32'h0000_0800;
        drive_transfer(16'h0030, 32'h0000_0800, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
        total++;
        if (recs.size() !== 2 || recs[0].addr !== 32'h7FC || recs[0].wdata !== 32'h800 ||
            recs[1].addr !== 32'h800 || recs[1].wdata !== regFile[5]) begin
            bad++;
            $display("[TB] FAIL stm_base_store: got n=%0d expected r4=800@7fc r5@800", recs.size());
        end
        total++;
        if (wbEnSeen !== 1'b1 || wbDataSeen !== 32'h7F8) begin
            bad++;
            $display("[TB] FAIL stm_base_wb: got en=%b data=%0h expected en=1 data=7f8", wbEnSeen, wbDataSeen);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int strobes;
        randomize_regfile();
        @(negedge clk);
        regList = 16'h00F0; base = 32'h1000; baseIdx = 4'd0;
        pBit = 1'b0; uBit = 1'b1; wBit = 1'b1; lBit = 1'b0;
        start = 1'b1; memOk = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        memOk = 1'b0;
        @(negedge clk);
        total++;
        if (memAddr !== 32'h1004 || memWrite !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_beat1: got addr=%0h wr=%b expected 1004 1", memAddr, memWrite);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({memRead, memWrite, wrEn, busy, done, wbEn} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_outputs: got %b expected 000000",
                     {memRead, memWrite, wrEn, busy, done, wbEn});
        end
        strobes = 0;
        memOk = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || wbEn || busy) strobes++;
        end
        total++;
        if (strobes !== 0) begin
            bad++;
            $display("[TB] FAIL rstmid_no_wb: got %0d active cycles expected 0", strobes);
        end
        drive_transfer(16'h00F0, 32'h1000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
        total++;
        if (recs.size() !== 4 || recs[0].addr !== 32'h1000 || recs[0].wdata !== regFile[4] ||
            wbDataSeen !== 32'h1010 || wbEnSeen !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_restart: got n=%0d addr0=%0h wb=%0h expected 4 1000 1010",
                     recs.size(), recs.size() > 0 ? recs[0].addr : 32'hX, wbDataSeen);
        end
    endtask

    task automatic test_random();
        logic [15:0] list;
        logic [31:0] b;
        logic [3:0]  bidx;
        logic        p, u, w, l;
        int          k;
        int          waits;
        for (int t = 0; t < 40; t++) begin
            list = 16'($urandom);
            if ($urandom_range(0, 7) == 0) list = 16'h0;
            else if ($urandom_range(0, 3) == 0) list = 16'(1) << $urandom_range(0, 15);
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(0, 15));
            bidx = 4'($urandom);
            {p, u, w, l} = 4'($urandom);
            randomize_regfile();
            build_model(list, b, bidx, p, u, w, l);
            drive_transfer(list, b, bidx, p, u, w, l, -1, 0, 1'b1);
            k = 0;
            waits = 0;
            for (int j = 0; j < recs.size(); j++) begin
                total++;
                if (k >= expIdx.size()) begin
                    bad++;
                    $display("[TB] FAIL rnd%0d_overrun: got beat %0d expected at most %0d", t, k, expIdx.size());
                    break;
                end
                if (recs[j].addr !== expAddr[k] || recs[j].rd !== l || recs[j].wr !== !l) begin
                    bad++;
                    $display("[TB] FAIL rnd%0d_req%0d: got addr=%0h rd=%b wr=%b expected addr=%0h rd=%b",
                             t, j, recs[j].addr, recs[j].rd, recs[j].wr, expAddr[k], l);
                end
                if (!recs[j].ok) begin
                    waits++;
                end else begin
                    total++;
                    if (l && (recs[j].wrEn !== 1'b1 || recs[j].wrIdx !== 4'(expIdx[k]) ||
                              recs[j].wrData !== recs[j].rdata)) begin
                        bad++;
                        $display("[TB] FAIL rnd%0d_load%0d: got en=%b idx=%0d data=%0h expected 1 %0d %0h",
                                 t, k, recs[j].wrEn, recs[j].wrIdx, recs[j].wrData, expIdx[k], recs[j].rdata);
                    end else if (!l && (recs[j].rdIdx !== 4'(expIdx[k]) ||
                                        recs[j].wdata !== regFile[expIdx[k]])) begin
                        bad++;
                        $display("[TB] FAIL rnd%0d_store%0d: got idx=%0d data=%0h expected %0d %0h",
                                 t, k, recs[j].rdIdx, recs[j].wdata, expIdx[k], regFile[expIdx[k]]);
                    end
                    k++;
                end
            end
            total++;
            if (k !== expIdx.size() || doneCycle !== expIdx.size() + 1 + waits) begin
                bad++;
                $display("[TB] FAIL rnd%0d_count: got beats=%0d done_cycle=%0d expected %0d %0d",
                         t, k, doneCycle, expIdx.size(), expIdx.size() + 1 + waits);
            end
            total++;
            if (wbEnSeen !== expWbEn || wbDataSeen !== expWbData) begin
                bad++;
                $display("[TB] FAIL rnd%0d_wb: got en=%b data=%0h expected en=%b data=%0h",
                         t, wbEnSeen, wbDataSeen, expWbEn, expWbData);
            end
            total++;
            if (extraWr !== 0 || busyBad !== 0 || accessInDone !== 0 || idleFlags !== 5'b0) begin
                bad++;
                $display("[TB] FAIL rnd%0d_status: got extra_wr=%0d busy_bad=%0d done_access=%0d idle=%b expected 0 0 0 00000",
                         t, extraWr, busyBad, accessInDone, idleFlags);
            end
        end
    endtask

    initial begin
        randomize_regfile();
        test_reset();
        test_stmia();
        test_ldmdb_wb();
        test_ldm_base_in_list();
        test_wait_states();
        test_empty_list();
        test_stm_base_in_list();
        test_reset_mid_xfer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
